// File: rtl/cpm_req_que_pkg.sv
// cpm_pkg: shared defaults for the per-lane request queue.
//   CPM_REQ_DW / CPM_IDX_AW / CPM_DAT_DW / CPM_DEPTH / CPM_STV_TH : default
//   parameter values used by cpm_req_que and cpm_req_lane.
//   cpm_entry_t : one queued request {idx, dat} at the default widths.
package cpm_pkg;

  localparam int CPM_REQ_DW = 4;
  localparam int CPM_IDX_AW = 2;
  localparam int CPM_DAT_DW = 16;
  localparam int CPM_DEPTH  = 4;
  localparam int CPM_STV_TH = 15;

  typedef struct packed {
    logic [CPM_IDX_AW-1:0] idx;
    logic [CPM_DAT_DW-1:0] dat;
  } cpm_entry_t;

endpackage

// File: rtl/cpm_req_que_lane.sv
// cpm_req_lane: one requester lane -- a DEPTH-entry FIFO of {idx, dat},
// its occupancy count and (optionally) a head wait counter.
//   clk, rst          : clock, asynchronous active-high reset
//   psh_vld/idx/dat   : push request and entry
//   psh_rdy           : lane not full (registered state only)
//   req_arb, req_idx  : head valid and head index, to the arbiter
//   gnt_arb           : grant; pops the head in the same cycle
//   out_vld/idx/dat   : popped entry, presented the cycle after the grant
//   occ               : occupancy, 0..DEPTH
//   starve            : head has waited STV_TH cycles
// Macro CPM_REQ_QUE_STARVE_EN enables the wait counter; otherwise starve=0.
module cpm_req_lane
  import cpm_pkg::*;
#(
  parameter int IDX_AW = CPM_IDX_AW,
  parameter int DAT_DW = CPM_DAT_DW,
  parameter int DEPTH  = CPM_DEPTH,
  parameter int STV_TH = CPM_STV_TH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psh_vld,
  input  logic [IDX_AW-1:0]        psh_idx,
  input  logic [DAT_DW-1:0]        psh_dat,
  output logic                     psh_rdy,
  output logic                     req_arb,
  output logic [IDX_AW-1:0]        req_idx,
  input  logic                     gnt_arb,
  output logic                     out_vld,
  output logic [IDX_AW-1:0]        out_idx,
  output logic [DAT_DW-1:0]        out_dat,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [IDX_AW-1:0] idx;
    logic [DAT_DW-1:0] dat;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  // Ready depends only on the stored count, so a pop in the same cycle
  // never frees room for a push into a full lane.
  assign psh_rdy = (cnt != FULL);
  assign req_arb = (cnt != '0);
  assign req_idx = mem[rptr].idx;
  assign occ     = cnt;
  assign push    = psh_vld && psh_rdy;
  assign pop     = gnt_arb && req_arb;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{idx: psh_idx, dat: psh_dat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      out_vld <= 1'b0;
      out_idx <= '0;
      out_dat <= '0;
    end else begin
      out_vld <= pop;
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr    <= rptr + PW'(1);
        out_idx <= mem[rptr].idx;
        out_dat <= mem[rptr].dat;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef CPM_REQ_QUE_STARVE_EN
  localparam logic [7:0] STV_LIM = 8'(STV_TH);
  logic [7:0] wcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (pop || !req_arb) begin
      wcnt <= '0;
    end else if (wcnt != STV_LIM) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  assign starve = (wcnt == STV_LIM);
`else
  // STV_TH is at least 1, so this is a constant 0 that still consumes the
  // parameter in the counter-less build.
  assign starve = (STV_TH == 0);
`endif

endmodule

// File: rtl/cpm_req_que.sv
// cpm_req_que: REQ_DW independent request FIFOs feeding an external arbiter.
//   clk, rst          : clock, asynchronous active-high reset
//   PSH_VLD/IDX/DAT   : per-lane push request and entry
//   PSH_RDY           : per-lane not full
//   REQ_ARB, REQ_IDX  : per-lane head valid / head index, to the arbiter
//   GNT_ARB           : per-lane grant from the arbiter
//   OUT_VLD/IDX/DAT   : per-lane issued entry, one cycle after the grant
//   OCC               : per-lane occupancy
//   STARVE            : per-lane head waited STV_TH cycles
// Macro CPM_REQ_QUE_STARVE_EN enables the starvation counters.
module cpm_req_que
  import cpm_pkg::*;
#(
  parameter int REQ_DW = CPM_REQ_DW,
  parameter int IDX_AW = CPM_IDX_AW,
  parameter int DAT_DW = CPM_DAT_DW,
  parameter int DEPTH  = CPM_DEPTH,
  parameter int STV_TH = CPM_STV_TH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_DW-1:0]                    PSH_VLD,
  input  logic [REQ_DW-1:0][IDX_AW-1:0]        PSH_IDX,
  input  logic [REQ_DW-1:0][DAT_DW-1:0]        PSH_DAT,
  output logic [REQ_DW-1:0]                    PSH_RDY,
  output logic [REQ_DW-1:0]                    REQ_ARB,
  output logic [REQ_DW-1:0][IDX_AW-1:0]        REQ_IDX,
  input  logic [REQ_DW-1:0]                    GNT_ARB,
  output logic [REQ_DW-1:0]                    OUT_VLD,
  output logic [REQ_DW-1:0][IDX_AW-1:0]        OUT_IDX,
  output logic [REQ_DW-1:0][DAT_DW-1:0]        OUT_DAT,
  output logic [REQ_DW-1:0][$clog2(DEPTH):0]   OCC,
  output logic [REQ_DW-1:0]                    STARVE
);

  for (genvar i = 0; i < REQ_DW; i++) begin : g_lane
    cpm_req_lane #(
      .IDX_AW (IDX_AW),
      .DAT_DW (DAT_DW),
      .DEPTH  (DEPTH),
      .STV_TH (STV_TH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .psh_vld (PSH_VLD[i]),
      .psh_idx (PSH_IDX[i]),
      .psh_dat (PSH_DAT[i]),
      .psh_rdy (PSH_RDY[i]),
      .req_arb (REQ_ARB[i]),
      .req_idx (REQ_IDX[i]),
      .gnt_arb (GNT_ARB[i]),
      .out_vld (OUT_VLD[i]),
      .out_idx (OUT_IDX[i]),
      .out_dat (OUT_DAT[i]),
      .occ     (OCC[i]),
      .starve  (STARVE[i])
    );
  end

endmodule

// File: tb/tb_cpm_req_que.sv
module tb_cpm_req_que;
  import cpm_pkg::*;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int D  = 4;

`ifdef CPM_REQ_QUE_STARVE_EN
  localparam logic STV_EN = 1'b1;
`else
  localparam logic STV_EN = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic [N-1:0]            psh_vld;
  logic [N-1:0][AW-1:0]    psh_idx;
  logic [N-1:0][DW-1:0]    psh_dat;
  logic [N-1:0]            psh_rdy;
  logic [N-1:0]            req_arb;
  logic [N-1:0][AW-1:0]    req_idx;
  logic [N-1:0]            gnt_arb;
  logic [N-1:0]            out_vld;
  logic [N-1:0][AW-1:0]    out_idx;
  logic [N-1:0][DW-1:0]    out_dat;
  logic [N-1:0][2:0]       occ;
  logic [N-1:0]            starve;

  int n_assert = 0;
  int n_fail   = 0;

  cpm_req_que #(
    .REQ_DW (N),
    .IDX_AW (AW),
    .DAT_DW (DW),
    .DEPTH  (D),
    .STV_TH (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .PSH_VLD (psh_vld),
    .PSH_IDX (psh_idx),
    .PSH_DAT (psh_dat),
    .PSH_RDY (psh_rdy),
    .REQ_ARB (req_arb),
    .REQ_IDX (req_idx),
    .GNT_ARB (gnt_arb),
    .OUT_VLD (out_vld),
    .OUT_IDX (out_idx),
    .OUT_DAT (out_dat),
    .OCC     (occ),
    .STARVE  (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst     = 1'b1;
    psh_vld = '0;
    psh_idx = '0;
    psh_dat = '0;
    gnt_arb = '0;
    tick();
    tick();

    // reset state
    chk("rst_occ",     64'(occ), 64'h0);
    chk("rst_rdy",     64'(psh_rdy), 64'hF);
    chk("rst_arb",     64'(req_arb), 64'h0);
    chk("rst_outvld",  64'(out_vld), 64'h0);
    chk("rst_outdat",  64'(out_dat), 64'h0);
    chk("rst_starve",  64'(starve), 64'h0);
    rst = 1'b0;
    tick();

    // single push/grant on lane 0
    psh_vld    = 4'b0001;
    psh_idx[0] = 2'd2;
    psh_dat[0] = 16'h00A5;
    tick();
    psh_vld = '0;
    chk("l0_arb",  64'(req_arb), 64'b0001);
    chk("l0_idx",  64'(req_idx[0]), 64'd2);
    chk("l0_occ",  64'(occ[0]), 64'd1);
    gnt_arb = 4'b0001;
    tick();
    gnt_arb = '0;
    chk("l0_outvld", 64'(out_vld), 64'b0001);
    chk("l0_outdat", 64'(out_dat[0]), 64'h00A5);
    chk("l0_outidx", 64'(out_idx[0]), 64'd2);
    chk("l0_arb0",   64'(req_arb), 64'b0000);
    tick();
    chk("l0_vld_low",  64'(out_vld), 64'b0000);
    chk("l0_dat_hold", 64'(out_dat[0]), 64'h00A5);

    // lane 1 fill to full, then push+grant on full lane
    psh_vld = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      psh_idx[1] = AW'(k);
      psh_dat[1] = 16'h1000 + 16'(k);
      tick();
    end
    chk("l1_occ_full", 64'(occ[1]), 64'd4);
    chk("l1_rdy_low",  64'(psh_rdy[1]), 64'd0);
    chk("l1_head_idx", 64'(req_idx[1]), 64'd0);
    psh_idx[1] = 2'd3;
    psh_dat[1] = 16'hBEEF;
    gnt_arb    = 4'b0010;
    tick();
    psh_vld = '0;
    chk("l1_occ_3",   64'(occ[1]), 64'd3);
    chk("l1_pop_vld", 64'(out_vld), 64'b0010);
    chk("l1_pop_dat", 64'(out_dat[1]), 64'h1000);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("l1_drain_dat", 64'(out_dat[1]), 64'h1000 + 64'(k));
      chk("l1_drain_idx", 64'(out_idx[1]), 64'(k));
    end
    gnt_arb = '0;
    chk("l1_empty", 64'(occ[1]), 64'd0);
    tick();
    chk("l1_no_beef", 64'(out_vld), 64'b0000);

    // lane 2 steady state at OCC=2 across pointer wrap
    psh_vld = 4'b0100;
    psh_idx[2] = 2'd0;
    psh_dat[2] = 16'h2000;
    tick();
    psh_idx[2] = 2'd1;
    psh_dat[2] = 16'h2001;
    tick();
    chk("l2_occ2", 64'(occ[2]), 64'd2);
    gnt_arb = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      psh_idx[2] = AW'(k + 2);
      psh_dat[2] = 16'h2002 + 16'(k);
      tick();
      chk("l2_occ_steady", 64'(occ[2]), 64'd2);
      chk("l2_out_vld",    64'(out_vld[2]), 64'd1);
      chk("l2_out_dat",    64'(out_dat[2]), 64'h2000 + 64'(k));
      chk("l2_out_idx",    64'(out_idx[2]), 64'(k % 4));
    end
    psh_vld = '0;
    tick();
    chk("l2_tail_a", 64'(out_dat[2]), 64'h200A);
    tick();
    chk("l2_tail_b", 64'(out_dat[2]), 64'h200B);
    gnt_arb = '0;
    chk("l2_empty", 64'(occ[2]), 64'd0);

    // grant to empty lane 3
    gnt_arb = 4'b1000;
    tick();
    gnt_arb = '0;
    chk("l3_empty_vld", 64'(out_vld), 64'b0000);
    chk("l3_empty_occ", 64'(occ), 64'h0);
    psh_vld    = 4'b1000;
    psh_idx[3] = 2'd1;
    psh_dat[3] = 16'h3333;
    tick();
    psh_vld = '0;
    gnt_arb = 4'b1000;
    tick();
    gnt_arb = '0;
    chk("l3_after_dat", 64'(out_dat[3]), 64'h3333);
    chk("l3_after_vld", 64'(out_vld), 64'b1000);

    // starvation on lane 0
    psh_vld    = 4'b0001;
    psh_idx[0] = 2'd3;
    psh_dat[0] = 16'h0F0F;
    tick();
    psh_vld = '0;
    for (int k = 1; k < 15; k++) tick();
    chk("stv_pre",  64'(starve[0]), 64'd0);
    tick();
    chk("stv_hit",  64'(starve[0]), 64'(STV_EN));
    tick();
    chk("stv_hold", 64'(starve[0]), 64'(STV_EN));
    gnt_arb = 4'b0001;
    tick();
    gnt_arb = '0;
    chk("stv_clear",   64'(starve[0]), 64'd0);
    chk("stv_pop_dat", 64'(out_dat[0]), 64'h0F0F);

    // async reset with all lanes at OCC=3
    psh_vld = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      psh_dat = {4{16'h5A00 + 16'(k)}};
      tick();
    end
    psh_vld = '0;
    chk("pre_rst_occ", 64'(occ), 64'b011_011_011_011);
    gnt_arb = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_occ", 64'(occ), 64'h0);
    chk("arst_arb", 64'(req_arb), 64'h0);
    chk("arst_rdy", 64'(psh_rdy), 64'hF);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_arb", 64'(req_arb), 64'h0);
    chk("post_rst_vld", 64'(out_vld), 64'h0);
    tick();
    gnt_arb = '0;
    chk("post_rst_vld2", 64'(out_vld), 64'h0);
    chk("post_rst_occ",  64'(occ), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpm_req_que.md
CPM_REQ_QUE -- requirements
Module: CPM_REQ_QUE

Interface
REQ-001 SHALL have parameter REQ_DW, default 4, number of requester lanes.
REQ-002 SHALL have parameter IDX_AW, default 2, target index width.
REQ-003 SHALL have parameter DAT_DW, default 16, payload width.
REQ-004 SHALL have parameter DEPTH, default 4, entries per lane; power of two, at least 2.
REQ-005 SHALL have parameter STV_TH, default 15, starvation threshold in cycles, range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port PSH_VLD, input, [REQ_DW]: per-lane push request.
REQ-009 SHALL have port PSH_IDX, input, [REQ_DW][IDX_AW]: per-lane target index.
REQ-010 SHALL have port PSH_DAT, input, [REQ_DW][DAT_DW]: per-lane payload.
REQ-011 SHALL have port PSH_RDY, output, [REQ_DW]: lane not full.
REQ-012 SHALL have port REQ_ARB, output, [REQ_DW]: head valid, to the arbiter.
REQ-013 SHALL have port REQ_IDX, output, [REQ_DW][IDX_AW]: head target index, to the arbiter.
REQ-014 SHALL have port GNT_ARB, input, [REQ_DW]: per-lane grant, from the arbiter.
REQ-015 SHALL have port OUT_VLD, output, [REQ_DW]: granted entry issued.
REQ-016 SHALL have ports OUT_IDX, output, [REQ_DW][IDX_AW], and OUT_DAT, output, [REQ_DW][DAT_DW]: issued entry.
REQ-017 SHALL have port OCC, output, [REQ_DW][$clog2(DEPTH)+1]: per-lane occupancy.
REQ-018 SHALL have port STARVE, output, [REQ_DW]: head waited at least STV_TH cycles.

Function
REQ-019 SHALL hold one independent FIFO per lane, each storing {idx, dat}.
REQ-020 SHALL perform a push when PSH_VLD[i] && PSH_RDY[i]; the entry is visible on REQ_ARB/REQ_IDX the next cycle (no bypass).
REQ-021 SHALL drive PSH_RDY[i] = (OCC[i] != DEPTH), registered-state only, with no combinational path from GNT_ARB.
REQ-022 SHALL drive REQ_ARB[i] = (OCC[i] != 0) and REQ_IDX[i] = head idx, combinationally from lane state.
REQ-023 SHALL pop the head when GNT_ARB[i] && REQ_ARB[i] (same cycle as the grant), and the next cycle present OUT_VLD[i]=1 with OUT_IDX/OUT_DAT = the popped entry.
REQ-024 SHALL keep OUT_VLD[i]=0 on all other cycles; OUT_IDX/OUT_DAT hold their last value.
REQ-025 SHALL ignore a grant to an empty lane: no pop, no OUT_VLD, no pointer change.
REQ-026 SHALL handle a simultaneous push and pop on a non-empty lane by leaving OCC unchanged, with both take effect.
REQ-027 SHALL refuse a push to a full lane (PSH_RDY=0) even if a pop occurs in that cycle.
REQ-028 SHALL have read and write pointers wrap modulo DEPTH.
REQ-029 SHALL clear the per-lane wait counter on pop or when the lane is empty, otherwise increment it each cycle REQ_ARB[i]=1, saturating at STV_TH.
REQ-030 SHALL drive STARVE[i] = (wait counter == STV_TH), registered.

Reset
REQ-031 SHALL, while rst=1 and asynchronously, force pointers, OCC, wait counters, OUT_VLD and STARVE to 0, OUT_IDX/OUT_DAT to 0, and PSH_RDY to all ones; storage RAM is not reset.
REQ-032 SHALL discard all pending entries when reset is asserted mid-operation; the first cycle after deassertion shows REQ_ARB=0.

Configuration
REQ-033 SHALL, with macro CPM_REQ_QUE_STARVE_EN defined, implement the wait counters and the STARVE logic.
REQ-034 SHALL, without it, tie STARVE to 0, instantiate no wait counters, and leave all other behaviour identical.

Structure
REQ-035 SHALL place REQ_DW/IDX_AW/DAT_DW defaults and a typedef of the lane entry struct {idx, dat} in shared package CPM_PKG.
REQ-036 SHALL implement one lane (FIFO, occupancy, wait counter) as sub-module CPM_REQ_LANE, instantiated REQ_DW times in a generate loop.

Verification
REQ-037 SHALL cover: push idx=2, dat=0x00A5 on lane 0 -> REQ_ARB=0001 and REQ_IDX[0]=2 the next cycle; grant it -> OUT_VLD=0001, OUT_DAT[0]=0x00A5 one cycle later.
REQ-038 SHALL cover: 4 pushes on lane 1 with no grants -> OCC[1]=4 and PSH_RDY[1]=0; push plus grant in the same cycle -> push refused and OCC[1]=3.
REQ-039 SHALL cover: OCC[2]=2 with push and grant every cycle for 10 cycles -> OCC[2] stays 2 and output data is in FIFO order across pointer wrap.
REQ-040 SHALL cover: GNT_ARB=1000 with lane 3 empty -> OUT_VLD=0 and OCC unchanged.
REQ-041 SHALL cover: lane 0 head ungranted 15 cycles (macro defined) -> STARVE[0]=1 at cycle 15 and 0 the cycle after the pop; macro undefined -> STARVE always 0.
REQ-042 SHALL cover: rst pulsed with lanes at OCC=3 -> OCC=0, REQ_ARB=0 and PSH_RDY=1111 immediately, with no OUT_VLD after release.
